// File: rtl/qei_pulse_gen.sv
// rtl/qei_pulse_gen.sv - quadrature encoder emulator: step commands in, chA/chB edges and signed position out
module qei_pulse_gen #(
    parameter int STEP_W   = 16,
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_dir_i,
    input  logic [STEP_W-1:0]   cmd_steps_i,
    input  logic [PERIOD_W-1:0] cmd_period_i,
    input  logic                abort_i,
    input  logic                pos_clear_i,
    output logic                cha_o,
    output logic                chb_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [POS_W-1:0]    position_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    logic                dir_q;
    logic [STEP_W-1:0]   remaining_q;
    logic [PERIOD_W-1:0] reload_q;
    logic [PERIOD_W-1:0] timer_q;
    logic [1:0]          phase_q;
    logic [POS_W-1:0]    position_q;
    logic                busy_q;
    logic                done_q;

    logic [1:0]          phase_d;
    logic [POS_W-1:0]    position_d;
    logic [PERIOD_W-1:0] cmd_reload;

    // Phase is {chA,chB}; forward walks 00->10->11->01, reverse walks it backwards.
    always_comb begin
        phase_d = phase_q;
        case ({dir_q, phase_q})
            3'b1_00: phase_d = 2'b10;
            3'b1_10: phase_d = 2'b11;
            3'b1_11: phase_d = 2'b01;
            3'b1_01: phase_d = 2'b00;
            3'b0_00: phase_d = 2'b01;
            3'b0_01: phase_d = 2'b11;
            3'b0_11: phase_d = 2'b10;
            3'b0_10: phase_d = 2'b00;
            default: phase_d = phase_q;
        endcase
    end

    always_comb begin
        position_d = dir_q ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));
        cmd_reload = (cmd_period_i == '0) ? '0 : (cmd_period_i - PERIOD_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            reload_q    <= '0;
            timer_q     <= '0;
            phase_q     <= 2'b00;
            position_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_steps_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            dir_q       <= cmd_dir_i;
                            remaining_q <= cmd_steps_i;
                            reload_q    <= cmd_reload;
                            timer_q     <= cmd_reload;
                            busy_q      <= 1'b1;
                            state_q     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (timer_q == '0) begin
                        phase_q     <= phase_d;
                        position_q  <= position_d;
                        remaining_q <= remaining_q - STEP_W'(1);
                        timer_q     <= reload_q;
                        if (remaining_q == STEP_W'(1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - PERIOD_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Clearing wins over a same-cycle edge; the channel edge above still lands.
            if (pos_clear_i) begin
                position_q <= '0;
            end
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign cha_o       = phase_q[1];
    assign chb_o       = phase_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign position_o  = position_q;

endmodule

// File: doc/qei_pulse_gen.md
# qei_pulse_gen

Quadrature encoder signal generator: accepts step commands (direction, edge count, edge period) over a valid/ready handshake and drives two-channel quadrature outputs chA/chB, one channel transition per step. It is the transmit-side counterpart of the motor-encoder QEI decoder. It serves as an encoder emulator for hardware-in-the-loop motor simulation and as a stimulus source for closed-loop decoder verification. It also keeps a signed running position count of emitted edges.

## Interface
- STEP_W, 16: width of cmd_steps
- PERIOD_W, 16: width of cmd_period (clocks per quadrature edge)
- POS_W, 32: width of position
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high when the generator is in IDLE; transfer occurs when cmd_valid && cmd_ready
- cmd_dir  in  1  1 = forward (A leads B), 0 = reverse (B leads A)
- cmd_steps  in  STEP_W  number of quadrature edges to emit
- cmd_period  in  PERIOD_W  clocks between edges; 0 is treated as 1
- abort  in  1  stop current command; ignored in IDLE
- pos_clear  in  1  synchronous clear of position to 0
- chA  out  1  encoder channel A, registered
- chB  out  1  encoder channel B, registered
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final edge of a command
- position  out  POS_W  signed count: +1 per forward edge, −1 per reverse edge

## Operation
- Phase register is 2 bits, {chA,chB}. Forward sequence: 00→10→11→01→00. Reverse sequence: 00→01→11→10→00. Phase persists across commands and aborts, so a new command continues from the current levels.
- IDLE:
  - cmd_ready=1, busy=0.
  - On transfer with cmd_steps≠0: latch dir and steps into remaining, load timer=max(cmd_period,1)−1, go to RUN.
  - On transfer with cmd_steps=0: stay in IDLE, pulse done in the next cycle, no edges.
- RUN:
  - cmd_ready=0, busy=1.
  - Timer decrements each clock. When timer==0: advance phase one step in the latched direction, update position ±1, decrement remaining, reload timer=period−1.
  - If remaining was 1 at that edge: go to IDLE and assert done in the following cycle.
- abort in RUN: go to IDLE at the next clock. No edge is emitted on that clock even if timer==0. done is not pulsed. Channels hold their levels. remaining is discarded.
- pos_clear takes priority over a same-cycle edge: position becomes 0, but the channel edge is still emitted.
- position wraps modulo 2^POS_W (two's complement).
- Reset values: chA=0, chB=0, position=0, busy=0, done=0, state IDLE (cmd_ready=1 in the first cycle after rst deasserts). rst mid-command aborts immediately; no done.
- All outputs are registered except cmd_ready, which is decoded from the state register.

## Timing
- For a command accepted at clock edge k with period P≥1 and N steps:
  - Channel transitions occur at edges k+P, k+2P, …, k+N·P.
  - done is high in the cycle following edge k+N·P. cmd_ready is high in the same cycle.
- Back-to-back: a command offered while done is high is accepted that cycle. Its first edge follows P clocks later.
- P=1 produces one channel change per clock. The minimum A-to-B separation is 1 clock.
- position updates on the same clock edge as the channel change.
- Throughput: N·P+1 clocks per command, including the IDLE accept cycle.

## Test plan
- Reset, then forward: cmd_dir=1, steps=8, period=4 → A/B sequence 10,11,01,00,10,11,01,00 with transitions every 4 clocks; position=8; done pulses once, 33 clocks after accept.
- Reverse from position 8: dir=0, steps=3, period=1 → phases 01,11,10 on consecutive clocks; position=5; busy high for exactly 3 cycles.
- Abort: dir=1, steps=100, period=10, abort asserted 25 clocks after accept → exactly 2 edges emitted, position +2, no done, cmd_ready returns the next clock, channels frozen.
- Edge cases: steps=0 → done one cycle later, channels and position unchanged. period=0 → behaves as period=1.
- pos_clear asserted on the same clock as an edge → position=0 while the channel still toggles. Reverse from position 0 for 1 step → position=0xFFFFFFFF.
- Loopback with the QEI decoder (COUNT_BOTH=1): forward 1200 edges at period 1000 → the decoder counts all edges with no missed transitions, and position matches the edge count.
